n4_ms_accumulator: RTL
======================

// Module: n4_ms_accumulator
// PURPOSE
// Sequential consumer of 4-bit sign-magnitude operands. Each accepted operand is
// converted to two's complement by an internal n4_ms_c2_converter instance,
// sign-extended to W bits and added to a running sum. After N_OPS operands the
// sum is presented on a valid/ready output port, then the block restarts.
// It sits directly downstream of the sign-magnitude source, in the arithmetic datapath.
// PARAMETERS
// W      8  accumulator / result width in bits, W >= 5
// N_OPS  4  operands per batch, N_OPS >= 1
// PORTS
// clock      in   1  single clock; all state updates on rising edge
// reset      in   1  asynchronous, active-high reset
// x3_x0_abs  in   4  operand magnitude
// sgn        in   1  operand sign, 1 = negative
// in_valid   in   1  operand present on x3_x0_abs/sgn
// in_ready   out  1  block accepts an operand this cycle
// sum        out  W  batch result, two's complement; valid only while out_valid=1
// out_valid  out  1  sum is available
// out_ready  in   1  downstream takes sum
// sat        out  1  at least one addition in this batch saturated
// err        out  1  at least one operand in this batch was unrepresentable
// BEHAVIOUR
// - Reset (asynchronous): state=ACC, acc=0, cnt=0, sat=0, err=0, out_valid=0,
//   in_ready=1, sum=0. Reset asserted mid-batch or mid-output discards everything.
// - States:
//   ACC: in_ready=1, out_valid=0.
//   OUT: in_ready=0, out_valid=1, sum=acc.
// - Operand accept: occurs when in_valid & in_ready on a rising edge.
// - Conversion: the converter output ow=1 when x3_x0_abs[3]=1, except -8
//   (x3_x0_abs=4'b1000, sgn=1). Such an operand is consumed and counted, but
//   acc is unchanged and err<=1.
// - Addition: otherwise, z3_z0 is sign-extended to W bits and added to acc using
//   W+1-bit signed arithmetic.
//   - On overflow, acc saturates to +(2^(W-1)-1) or -2^(W-1), and sat<=1.
//   - -0 (abs=0, sgn=1) adds 0. It is not an error.
// - Counting: cnt increments per accept.
//   - On the accept that makes cnt==N_OPS, the final acc update lands that edge,
//     cnt<=0 and state<=OUT.
//   - out_valid rises the cycle after the last accept (latency 1).
// - Output: in OUT, sum/sat/err are held stable until out_valid & out_ready.
//   - On that edge: state<=ACC, acc<=0, sat<=0, err<=0.
//   - in_ready rises the next cycle. No bypass: operand accept and result
//     handoff never share an edge.
// - Input back-pressure: in_valid while in OUT is ignored. The source must hold
//   the operand until in_ready.
// - out_ready while in ACC has no effect.
// - Flags: sat and err are sticky per batch and visible in both states.
// TESTING
// - W=8,N_OPS=4: +3,+5,-2,+1 -> out_valid 1 cycle after 4th accept, sum=8'd7, sat=0, err=0.
// - -8(1000,sgn=1),-8,-8,-8 -> sum=-32 (8'hE0), err=0. Operand +9 (1001,sgn=0) -> not added, err=1.
// - W=5: +7 x4 -> 7,14,15(sat),15 -> sum=5'd15, sat=1. Mirror with -8 x4 -> sum=-16, sat=1.
// - Hold out_ready=0 for 5 cycles in OUT with in_valid=1 -> sum stable, in_ready=0,
//   no operand lost. Release -> next batch starts from acc=0 with flags clear.
// - Assert reset after 2 accepts and again during OUT -> all outputs return to reset values
//   asynchronously; the next batch needs a full N_OPS operands.
// - -0 operand and in_valid toggling every cycle -> count only handshaked operands, sum unaffected by -0.

Source files
------------

// File: rtl/n4_ms_accumulator.sv
// n4_ms_accumulator: batch accumulator for 4-bit sign-magnitude operands.
// Each accepted operand is converted to two's complement, sign-extended and
// added with saturation to a W-bit running sum. After N_OPS operands the sum
// is offered on a valid/ready port together with sticky sat/err flags.

// Sign-magnitude to 4-bit two's complement converter. ow flags magnitudes
// that do not fit in 4-bit two's complement (all |x| >= 8 except -8).
module n4_ms_c2_converter (
  input  logic [3:0] x3_x0_abs,
  input  logic       sgn,
  output logic [3:0] z3_z0,
  output logic       ow
);

  // Negate the magnitude for negative operands; -0 maps to 0 and -8 to 4'b1000.
  always_comb begin
    z3_z0 = sgn ? (4'd0 - x3_x0_abs) : x3_x0_abs;
    ow    = x3_x0_abs[3] & ~(sgn & (x3_x0_abs[2:0] == 3'b000));
  end

endmodule

module n4_ms_accumulator #(
  parameter int W     = 8,
  parameter int N_OPS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   x3_x0_abs,
  input  logic         sgn,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sat,
  output logic         err
);

  // Counter only needs to reach N_OPS-1; it wraps to 0 on the last accept.
  localparam int               CNT_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_OPS - 1);

  // Saturation limits of the W-bit two's complement result.
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {
    ST_ACC = 1'b0,  // collecting operands
    ST_OUT = 1'b1   // presenting the batch result
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             sat_q,   sat_d;
  logic             err_q,   err_d;

  logic [3:0]       conv_z;
  logic             conv_ow;

  logic [W:0]       acc_ext;
  logic [W:0]       opd_ext;
  logic [W:0]       add_wide;
  logic             pos_ovf;
  logic             neg_ovf;
  logic [W-1:0]     add_res;
  logic             accept;
  logic             handoff;

  n4_ms_c2_converter u_conv (
    .x3_x0_abs (x3_x0_abs),
    .sgn       (sgn),
    .z3_z0     (conv_z),
    .ow        (conv_ow)
  );

  // Handshake qualifiers: operand accept only in ACC, result handoff only in OUT.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign accept    = in_valid  & in_ready;
  assign handoff   = out_ready & out_valid;

  // The sum port shows the accumulator only while the result is valid.
  assign sum = out_valid ? acc_q : '0;
  assign sat = sat_q;
  assign err = err_q;

  // One extra bit of headroom: the W+1-bit sum of two W-bit signed values
  // cannot wrap, so overflow shows up as the top two bits disagreeing.
  assign acc_ext  = {acc_q[W-1], acc_q};
  assign opd_ext  = {{(W-3){conv_z[3]}}, conv_z};
  assign add_wide = acc_ext + opd_ext;
  assign pos_ovf  = ~add_wide[W] &  add_wide[W-1];
  assign neg_ovf  =  add_wide[W] & ~add_wide[W-1];

  // Clamp the widened sum back into W bits.
  always_comb begin
    if (pos_ovf) begin
      add_res = POS_MAX;
    end else if (neg_ovf) begin
      add_res = NEG_MIN;
    end else begin
      add_res = add_wide[W-1:0];
    end
  end

  // Next-state logic: accumulate in ACC, wait for the consumer in OUT.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    err_d   = err_q;

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (conv_ow) begin
            // Unrepresentable operand: counted but not added.
            err_d = 1'b1;
          end else begin
            acc_d = add_res;
            if (pos_ovf || neg_ovf) begin
              sat_d = 1'b1;
            end
          end
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_OUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (handoff) begin
          state_d = ST_ACC;
          acc_d   = '0;
          sat_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State register with asynchronous reset that discards any batch in flight.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples the values from
    // before this edge, independent of statement order.
    if (reset) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

endmodule
